// File: rtl/core_wb_arbiter.sv
// core_wb_arbiter: round-robin writeback arbiter in front of the single
// register-file write port, plus a 32-entry busy scoreboard that EXEC uses
// to stall on RAW hazards and to hold back a second issue to a register
// that still has a write pending.
//
// Optional feature (macro CORE_WB_BYPASS_EN): adds rs1_fwd_value and
// rs2_fwd_value, and lets a source register stop reporting busy in the very
// cycle its write is presented to the register file.

module core_wb_arbiter #(
    parameter int N_REQ = 3
) (
    input  logic                   clk,
    input  logic                   rst,

    input  logic                   iss_valid,
    input  logic [4:0]             iss_rd,
    output logic                   iss_ready,

    input  logic [4:0]             rs1_id,
    input  logic [4:0]             rs2_id,
    output logic                   rs1_busy,
    output logic                   rs2_busy,

    input  logic [N_REQ-1:0]       req_valid,
    input  logic [N_REQ-1:0][4:0]  req_rd,
    input  logic [N_REQ-1:0][31:0] req_value,
    output logic [N_REQ-1:0]       req_ready,

    output logic                   reg_d_en,
    output logic                   reg_d_write,
    output logic [4:0]             reg_d_id,
    output logic [31:0]            reg_d_value
`ifdef CORE_WB_BYPASS_EN
    ,
    output logic [31:0]            rs1_fwd_value,
    output logic [31:0]            rs2_fwd_value
`endif
);

    localparam int PTR_W = $clog2(N_REQ);

    // Round-robin pointer: requester index that gets first look next cycle.
    logic [PTR_W-1:0] rr_ptr;
    logic [PTR_W-1:0] rr_ptr_next;

    // Winner of this cycle's arbitration.
    logic             grant_valid;
    logic [PTR_W-1:0] grant_idx;
    logic [N_REQ-1:0] grant_vec;
    int               scan_idx;

    // Destination registers with a write still outstanding.
    logic [31:0]      busy;
    logic [31:0]      busy_next;
    logic             issue_set;
    logic             retire_clear;

    // Rotating priority scan starting at rr_ptr; first valid requester wins.
    always_comb begin
        grant_valid = 1'b0;
        grant_idx   = '0;
        grant_vec   = '0;
        scan_idx    = 0;
        for (int k = 0; k < N_REQ; k++) begin
            scan_idx = int'(rr_ptr) + k;
            if (scan_idx >= N_REQ) begin
                scan_idx = scan_idx - N_REQ;
            end
            if (!grant_valid && req_valid[scan_idx]) begin
                grant_valid         = 1'b1;
                grant_idx           = PTR_W'(scan_idx);
                grant_vec[scan_idx] = 1'b1;
            end
        end
    end

    assign req_ready = grant_vec;

    // Pointer moves just past the winner so it has lowest priority next time.
    always_comb begin
        rr_ptr_next = rr_ptr;
        if (grant_valid) begin
            if (grant_idx == PTR_W'(N_REQ - 1)) begin
                rr_ptr_next = '0;
            end else begin
                rr_ptr_next = grant_idx + PTR_W'(1);
            end
        end
    end

    // Pointer register; holds whenever nobody was granted.
    always_ff @(posedge clk) begin
        if (rst) begin
            rr_ptr <= '0;
        end else begin
            rr_ptr <= rr_ptr_next;
        end
    end

    // Registered write port: strobes pulse per grant, id/value hold between writes.
    always_ff @(posedge clk) begin
        if (rst) begin
            reg_d_en    <= 1'b0;
            reg_d_write <= 1'b0;
            reg_d_id    <= '0;
            reg_d_value <= '0;
        end else begin
            reg_d_en    <= grant_valid;
            reg_d_write <= grant_valid;
            if (grant_valid) begin
                reg_d_id    <= req_rd[grant_idx];
                reg_d_value <= req_value[grant_idx];
            end
        end
    end

    // x0 never becomes busy, so issues to it are always accepted.
    assign iss_ready    = !iss_valid || (iss_rd == 5'd0) || !busy[iss_rd];
    assign issue_set    = iss_valid && iss_ready && (iss_rd != 5'd0);
    assign retire_clear = reg_d_en && (reg_d_id != 5'd0);

    // Scoreboard update: clear on the register-file write, set on accepted issue.
    always_comb begin
        busy_next = busy;
        if (retire_clear) begin
            busy_next[reg_d_id] = 1'b0;
        end
        if (issue_set) begin
            busy_next[iss_rd] = 1'b1;
        end
        busy_next[0] = 1'b0;
    end

    // Scoreboard register; reset drops every outstanding write.
    always_ff @(posedge clk) begin
        if (rst) begin
            busy <= '0;
        end else begin
            busy <= busy_next;
        end
    end

`ifdef CORE_WB_BYPASS_EN
    logic rs1_hit;
    logic rs2_hit;

    // A source being written this cycle is readable from the forward path.
    always_comb begin
        rs1_hit  = reg_d_en && (reg_d_id == rs1_id) && (rs1_id != 5'd0);
        rs2_hit  = reg_d_en && (reg_d_id == rs2_id) && (rs2_id != 5'd0);
        rs1_busy = busy[rs1_id] && !rs1_hit;
        rs2_busy = busy[rs2_id] && !rs2_hit;
    end

    assign rs1_fwd_value = reg_d_value;
    assign rs2_fwd_value = reg_d_value;
`else
    // Without forwarding, a source stays busy until the write has landed.
    always_comb begin
        rs1_busy = busy[rs1_id];
        rs2_busy = busy[rs2_id];
    end
`endif

endmodule

// File: tb/tb_core_wb_arbiter.sv
// tb_core_wb_arbiter: directed and randomized checks of core_wb_arbiter
// against a behavioural model (pending-register set, round-robin pointer,
// one-deep write-port pipeline). Define CORE_WB_BYPASS_EN to cover forwarding.

module tb_core_wb_arbiter;

    localparam int N = 3;

    logic                clk = 1'b0;
    logic                rst;
    logic                iss_valid;
    logic [4:0]          iss_rd;
    logic                iss_ready;
    logic [4:0]          rs1_id;
    logic [4:0]          rs2_id;
    logic                rs1_busy;
    logic                rs2_busy;
    logic [N-1:0]        req_valid;
    logic [N-1:0][4:0]   req_rd;
    logic [N-1:0][31:0]  req_value;
    logic [N-1:0]        req_ready;
    logic                reg_d_en;
    logic                reg_d_write;
    logic [4:0]          reg_d_id;
    logic [31:0]         reg_d_value;
`ifdef CORE_WB_BYPASS_EN
    logic [31:0]         rs1_fwd_value;
    logic [31:0]         rs2_fwd_value;
`endif

    int tests_run    = 0;
    int tests_failed = 0;

    bit          m_pending[32];
    int          m_ptr;
    bit          m_en;
    logic [4:0]  m_id;
    logic [31:0] m_val;
    logic [N-1:0] m_last_grant;

    always #5 clk = ~clk;

    core_wb_arbiter #(.N_REQ(N)) dut (
        .clk         (clk),
        .rst         (rst),
        .iss_valid   (iss_valid),
        .iss_rd      (iss_rd),
        .iss_ready   (iss_ready),
        .rs1_id      (rs1_id),
        .rs2_id      (rs2_id),
        .rs1_busy    (rs1_busy),
        .rs2_busy    (rs2_busy),
        .req_valid   (req_valid),
        .req_rd      (req_rd),
        .req_value   (req_value),
        .req_ready   (req_ready),
        .reg_d_en    (reg_d_en),
        .reg_d_write (reg_d_write),
        .reg_d_id    (reg_d_id),
        .reg_d_value (reg_d_value)
`ifdef CORE_WB_BYPASS_EN
        ,
        .rs1_fwd_value (rs1_fwd_value),
        .rs2_fwd_value (rs2_fwd_value)
`endif
    );

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests_run++;
        assert (obs === exp) else begin
            tests_failed++;
            $error("[TB] FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
        end
    endtask

    task automatic modelReset();
        foreach (m_pending[i]) m_pending[i] = 1'b0;
        m_ptr        = 0;
        m_en         = 1'b0;
        m_id         = '0;
        m_val        = '0;
        m_last_grant = '0;
    endtask

    function automatic bit srcBusy(input logic [4:0] rs);
        bit b;
        b = m_pending[rs];
`ifdef CORE_WB_BYPASS_EN
        if (m_en && m_id == rs && rs != 5'd0) b = 1'b0;
`endif
        return b;
    endfunction

    // One clock cycle: drive inputs, compare against the model, advance both.
    task automatic applyStimulus(input bit r, input bit iv, input logic [4:0] ird,
                                 input logic [4:0] r1, input logic [4:0] r2,
                                 input logic [N-1:0] v,
                                 input logic [N-1:0][4:0] rd,
                                 input logic [N-1:0][31:0] val);
        int g;
        int idx;
        bit exp_ready;
        logic [31:0] exp_grant;
        rst       = r;
        iss_valid = iv;
        iss_rd    = ird;
        rs1_id    = r1;
        rs2_id    = r2;
        req_valid = v;
        req_rd    = rd;
        req_value = val;
        #1;
        g = -1;
        for (int k = 0; k < N; k++) begin
            idx = (m_ptr + k) % N;
            if (g < 0 && v[idx]) g = idx;
        end
        exp_grant = (g < 0) ? 32'd0 : (32'd1 << g);
        exp_ready = !iv || ird == 5'd0 || !m_pending[ird];
        checkOutput("req_ready", 32'(req_ready), exp_grant);
        checkOutput("iss_ready", 32'(iss_ready), 32'(exp_ready));
        checkOutput("rs1_busy", 32'(rs1_busy), 32'(srcBusy(r1)));
        checkOutput("rs2_busy", 32'(rs2_busy), 32'(srcBusy(r2)));
        checkOutput("reg_d_en", 32'(reg_d_en), 32'(m_en));
        checkOutput("reg_d_write", 32'(reg_d_write), 32'(m_en));
        checkOutput("reg_d_id", 32'(reg_d_id), 32'(m_id));
        checkOutput("reg_d_value", reg_d_value, m_val);
`ifdef CORE_WB_BYPASS_EN
        checkOutput("rs1_fwd_value", rs1_fwd_value, m_val);
        checkOutput("rs2_fwd_value", rs2_fwd_value, m_val);
`endif
        if (r) begin
            modelReset();
        end else begin
            if (m_en && m_id != 5'd0) m_pending[m_id] = 1'b0;
            if (iv && exp_ready && ird != 5'd0) m_pending[ird] = 1'b1;
            m_last_grant = exp_grant[N-1:0];
            if (g >= 0) begin
                m_en  = 1'b1;
                m_id  = rd[g];
                m_val = val[g];
                m_ptr = (g + 1) % N;
            end else begin
                m_en = 1'b0;
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic idleCycle();
        applyStimulus(1'b0, 1'b0, 5'd0, 5'd0, 5'd0, '0, '0, '0);
    endtask

    task automatic resetCycle();
        applyStimulus(1'b1, 1'b0, 5'd0, 5'd0, 5'd0, '0, '0, '0);
    endtask

    logic [N-1:0]       cur_v;
    logic [N-1:0][4:0]  cur_rd;
    logic [N-1:0][31:0] cur_val;

    initial begin
        rst = 1'b1; iss_valid = 1'b0; iss_rd = '0; rs1_id = '0; rs2_id = '0;
        req_valid = '0; req_rd = '0; req_value = '0;
        @(posedge clk);
        #1;
        modelReset();
        checkOutput("reset_en", 32'(reg_d_en), 32'd0);
        checkOutput("reset_write", 32'(reg_d_write), 32'd0);
        checkOutput("reset_id", 32'(reg_d_id), 32'd0);
        checkOutput("reset_value", reg_d_value, 32'd0);

        // Issue rd=5 and watch it through a write by requester 1.
        idleCycle();
        applyStimulus(1'b0, 1'b1, 5'd5, 5'd5, 5'd0, '0, '0, '0);
        checkOutput("rs1_busy_after_issue", 32'(rs1_busy), 32'd1);
        applyStimulus(1'b0, 1'b0, 5'd0, 5'd5, 5'd0, 3'b010,
                      {5'd0, 5'd5, 5'd0}, {32'd0, 32'hDEADBEEF, 32'd0});
        checkOutput("wr5_en", 32'(reg_d_en), 32'd1);
        checkOutput("wr5_id", 32'(reg_d_id), 32'd5);
        checkOutput("wr5_value", reg_d_value, 32'hDEADBEEF);
`ifdef CORE_WB_BYPASS_EN
        checkOutput("wr5_rs1_busy_bypass", 32'(rs1_busy), 32'd0);
`else
        checkOutput("wr5_rs1_busy_write_cycle", 32'(rs1_busy), 32'd1);
`endif
        applyStimulus(1'b0, 1'b0, 5'd0, 5'd5, 5'd0, '0, '0, '0);
        checkOutput("wr5_rs1_busy_cleared", 32'(rs1_busy), 32'd0);

        // All three requesters valid continuously.
        resetCycle();
        for (int k = 0; k < 6; k++) begin
            applyStimulus(1'b0, 1'b0, 5'd0, 5'd0, 5'd0, 3'b111,
                          {5'd3, 5'd2, 5'd1}, {32'h33, 32'h22, 32'h11});
            checkOutput("rr_id_seq", 32'(reg_d_id), 32'((k % 3) + 1));
            checkOutput("rr_next_grant", 32'(req_ready), 32'd1 << ((k + 1) % 3));
        end

        // Requester 2 alone, then 0 and 2 together.
        resetCycle();
        applyStimulus(1'b0, 1'b0, 5'd0, 5'd0, 5'd0, 3'b100,
                      {5'd12, 5'd0, 5'd0}, {32'hC, 32'd0, 32'd0});
        checkOutput("solo2_id", 32'(reg_d_id), 32'd12);
        applyStimulus(1'b0, 1'b0, 5'd0, 5'd0, 5'd0, 3'b101,
                      {5'd12, 5'd0, 5'd10}, {32'hC, 32'd0, 32'hA});
        checkOutput("pair_first_id", 32'(reg_d_id), 32'd10);
        checkOutput("pair_next_grant", 32'(req_ready), 32'b100);
        applyStimulus(1'b0, 1'b0, 5'd0, 5'd0, 5'd0, 3'b100,
                      {5'd12, 5'd0, 5'd10}, {32'hC, 32'd0, 32'hA});
        checkOutput("pair_second_id", 32'(reg_d_id), 32'd12);

        // WAW block on rd=7 and x0 issue.
        resetCycle();
        applyStimulus(1'b0, 1'b1, 5'd7, 5'd0, 5'd0, '0, '0, '0);
        checkOutput("waw_blocked", 32'(iss_ready), 32'd0);
        applyStimulus(1'b0, 1'b1, 5'd7, 5'd0, 5'd0, 3'b001,
                      {5'd0, 5'd0, 5'd7}, {32'd0, 32'd0, 32'h77});
        checkOutput("waw_write_id", 32'(reg_d_id), 32'd7);
        checkOutput("waw_still_blocked", 32'(iss_ready), 32'd0);
        applyStimulus(1'b0, 1'b1, 5'd7, 5'd0, 5'd0, '0, '0, '0);
        checkOutput("waw_released", 32'(iss_ready), 32'd1);
        idleCycle();
        applyStimulus(1'b0, 1'b1, 5'd0, 5'd0, 5'd0, '0, '0, '0);
        checkOutput("x0_ready", 32'(iss_ready), 32'd1);
        checkOutput("x0_not_busy", 32'(rs1_busy), 32'd0);

        // Reset with busy[3] set and a grant in flight.
        resetCycle();
        applyStimulus(1'b0, 1'b1, 5'd3, 5'd3, 5'd0, '0, '0, '0);
        applyStimulus(1'b1, 1'b0, 5'd0, 5'd3, 5'd0, 3'b010,
                      {5'd0, 5'd3, 5'd0}, {32'd0, 32'h3333, 32'd0});
        checkOutput("midrst_en", 32'(reg_d_en), 32'd0);
        checkOutput("midrst_busy3", 32'(rs1_busy), 32'd0);
        applyStimulus(1'b0, 1'b0, 5'd0, 5'd3, 5'd0, 3'b111,
                      {5'd3, 5'd2, 5'd1}, {32'h33, 32'h22, 32'h11});
        checkOutput("midrst_first_id", 32'(reg_d_id), 32'd1);

        // Write-cycle view of rd=9.
        resetCycle();
        applyStimulus(1'b0, 1'b1, 5'd9, 5'd0, 5'd9, '0, '0, '0);
        applyStimulus(1'b0, 1'b0, 5'd0, 5'd0, 5'd9, 3'b001,
                      {5'd0, 5'd0, 5'd9}, {32'd0, 32'd0, 32'h12345678});
        checkOutput("fwd9_id", 32'(reg_d_id), 32'd9);
`ifdef CORE_WB_BYPASS_EN
        checkOutput("fwd9_rs2_busy", 32'(rs2_busy), 32'd0);
        checkOutput("fwd9_value", rs2_fwd_value, 32'h12345678);
`else
        checkOutput("fwd9_rs2_busy", 32'(rs2_busy), 32'd1);
`endif

        // Randomized traffic; requesters hold their payload until granted.
        resetCycle();
        cur_v = '0; cur_rd = '0; cur_val = '0;
        for (int c = 0; c < 400; c++) begin
            for (int i = 0; i < N; i++) begin
                if (!(cur_v[i] && !m_last_grant[i])) begin
                    cur_v[i]   = ($urandom_range(0, 9) < 6);
                    cur_rd[i]  = 5'($urandom_range(0, 7));
                    cur_val[i] = $urandom;
                end
            end
            applyStimulus(($urandom_range(0, 59) == 0), 1'($urandom_range(0, 1)),
                          5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)),
                          5'($urandom_range(0, 7)), cur_v, cur_rd, cur_val);
            if (rst) cur_v = '0;
        end

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
